// File: rtl/apb_regfile.sv
// apb_regfile: DATA_W x DEPTH register file.
// It has one core write port, two combinational core read ports and an APB slave
// port that gives the bus full read/write access with programmable wait states.
// host_wr flags each register the bus has written since the core last wrote it.
module apb_regfile #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int APB_WAIT = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd2_data,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [DEPTH-1:0]  host_wr
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   // One extra address bit so DEPTH itself (e.g. 8 with 3-bit addresses) is representable
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      WAIT_C  = 4'(APB_WAIT);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              paddr_ok;
   logic              apb_commit;

   assign paddr_ok   = {1'b0, paddr} < DEPTH_C;
   // pready is gated by psel so a master that abandons the transfer never sees it
   assign pready     = (state == ACCESS) && (wait_cnt == 4'd0) && psel;
   assign pslverr    = pready && !paddr_ok;
   assign prdata     = (pready && paddr_ok) ? regs[paddr] : '0;
   assign apb_commit = pready && pwrite && paddr_ok;

   // APB handshake sequencing and wait-state countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE:    if (psel && !penable) state <= SETUP;
            SETUP: begin
               state    <= ACCESS;
               wait_cnt <= WAIT_C;
            end
            ACCESS: begin
               if (!psel)                 state    <= IDLE;
               else if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
               else                       state    <= (psel && !penable) ? SETUP : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      logic              apb_hit;
      logic              core_hit;
      logic [DATA_W-1:0] q;
      logic              hw;

      assign apb_hit  = apb_commit && (paddr == IDX);
      assign core_hit = wr_en && (wr_addr == IDX);
      assign regs[i]    = q;
      assign host_wr[i] = hw;

      // Register update; a bus write beats a same-address core write and keeps the flag set
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q  <= '0;
            hw <= 1'b0;
         end else if (apb_hit) begin
            q  <= pwdata;
            hw <= 1'b1;
         end else if (core_hit) begin
            q  <= wr_data;
            hw <= 1'b0;
         end
      end
   end

   // Read mux with optional forwarding of this cycle's core write (or the winning bus write)
   function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if ({1'b0, a} < DEPTH_C) begin
         v = regs[a];
         if ((BYPASS != 0) && wr_en && (wr_addr == a))
            v = (apb_commit && (paddr == a)) ? pwdata : wr_data;
      end
      return v;
   endfunction

   // Read port 1
   always_comb rd1_data = rd_sel(rd1_addr);

   // Read port 2
   always_comb rd2_data = rd_sel(rd2_addr);

endmodule
